// File: rtl/contador_param.sv
// contador_param: parametrised up/down counter over a programmable range
// [MIN_VAL, MAX_VAL] with step size, run-time wrap/saturate selection,
// synchronous clamped load, limit decodes and sticky overflow/underflow flags.
//
// All range arithmetic is carried at WIDTH+1 bits so that saida+STEP and
// saida+R-STEP never truncate before the limit compare.
module contador_param #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 106,
    parameter int unsigned MIN_VAL     = 0,
    parameter int unsigned MAX_VAL     = (2**WIDTH) - 1,
    parameter int unsigned STEP        = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             carregar_i,
    input  logic [WIDTH-1:0] valor_carga_i,
    input  logic             acrescer_i,
    input  logic             decrecer_i,
    input  logic             modo_i,
    input  logic             limpar_flags_i,
    output logic [WIDTH-1:0] saida_o,
    output logic             no_maximo_o,
    output logic             no_minimo_o,
    output logic             estouro_o,
    output logic             subfluxo_o
);

    localparam int unsigned W1 = WIDTH + 1;

    // Range constants at the extended width used by the arithmetic.
    localparam logic [WIDTH:0] MIN_X    = W1'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_X    = W1'(MAX_VAL);
    localparam logic [WIDTH:0] STEP_X   = W1'(STEP);
    localparam logic [WIDTH:0] RANGE_X  = W1'(MAX_VAL - MIN_VAL + 1);
    localparam logic [WIDTH:0] DN_LIM_X = W1'(MIN_VAL + STEP);

    // Same constants at counter width for results and decodes.
    localparam logic [WIDTH-1:0] MIN_N = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_N = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] saida_q, saida_d;
    logic             estouro_q, estouro_d;
    logic             subfluxo_q, subfluxo_d;

    logic             cmd_up;
    logic             cmd_dn;
    logic [WIDTH-1:0] carga_clamp;
    logic [WIDTH:0]   atual_x;
    logic [WIDTH:0]   soma_x;
    logic             up_ovf;
    logic [WIDTH-1:0] up_res;
    logic             dn_unf;
    logic [WIDTH-1:0] dn_res;
    logic             set_ovf;
    logic             set_unf;

    // Count command decode: both or neither request means hold.
    always_comb begin
        cmd_up = acrescer_i & ~decrecer_i;
        cmd_dn = decrecer_i & ~acrescer_i;
    end

    // Load value clamped into the legal range.
    always_comb begin
        carga_clamp = valor_carga_i;
        if ({1'b0, valor_carga_i} < MIN_X) begin
            carga_clamp = MIN_N;
        end else if ({1'b0, valor_carga_i} > MAX_X) begin
            carga_clamp = MAX_N;
        end
    end

    // Up path: detect passing MAX_VAL, then wrap by one range or saturate.
    always_comb begin
        atual_x = {1'b0, saida_q};
        soma_x  = atual_x + STEP_X;
        up_ovf  = (soma_x > MAX_X);
        if (!up_ovf) begin
            up_res = WIDTH'(soma_x);
        end else if (modo_i) begin
            up_res = MAX_N;
        end else begin
            up_res = WIDTH'(soma_x - RANGE_X);
        end
    end

    // Down path: compare against MIN_VAL+STEP so the subtraction never borrows.
    always_comb begin
        dn_unf = (atual_x < DN_LIM_X);
        if (!dn_unf) begin
            dn_res = WIDTH'(atual_x - STEP_X);
        end else if (modo_i) begin
            dn_res = MIN_N;
        end else begin
            dn_res = WIDTH'(atual_x + RANGE_X - STEP_X);
        end
    end

    // Next-state select: load beats count beats hold; flag set beats clear.
    always_comb begin
        saida_d = saida_q;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (carregar_i) begin
            saida_d = carga_clamp;
        end else if (cmd_up) begin
            saida_d = up_res;
            set_ovf = up_ovf;
        end else if (cmd_dn) begin
            saida_d = dn_res;
            set_unf = dn_unf;
        end
        estouro_d  = set_ovf | (estouro_q  & ~limpar_flags_i);
        subfluxo_d = set_unf | (subfluxo_q & ~limpar_flags_i);
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            saida_q    <= RST_N;
            estouro_q  <= 1'b0;
            subfluxo_q <= 1'b0;
        end else begin
            saida_q    <= saida_d;
            estouro_q  <= estouro_d;
            subfluxo_q <= subfluxo_d;
        end
    end

    // Outputs: value and flags straight from registers, limits decoded.
    always_comb begin
        saida_o     = saida_q;
        estouro_o   = estouro_q;
        subfluxo_o  = subfluxo_q;
        no_maximo_o = (saida_q == MAX_N);
        no_minimo_o = (saida_q == MIN_N);
    end

endmodule
